// File: rtl/temp_display_pkg.sv
// Shared types and constants for the temperature seven-segment display:
// FSM encoding, glyphs, digit table and default timing/offset values.
package temp_display_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_MUL,
    S_DIV,
    S_BCD,
    S_LOAD
  } state_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_F     = 7'h0E;

  // Index 0 is the rightmost entry of the concatenation
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam int DIGIT_PERIOD_DEF = 500;
  localparam int F_OFFSET_DEF     = 32;
  localparam int DIV_CYCLES       = 12;
  localparam int BCD_CYCLES       = 9;

  // Double-dabble nibble correction
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/temp_seg7_display_if.sv
// Sensor-side inputs and display-side outputs of the temperature display.
interface temp_seg7_display_if;
  import temp_display_pkg::*;

  logic [7:0] temperature_input;
  logic       unit_select;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic       conv_done;

  modport master (
    output temperature_input, unit_select,
    input  seg, an, busy, conv_done
  );

  modport slave (
    input  temperature_input, unit_select,
    output seg, an, busy, conv_done
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Decimal digit to active-low segment pattern; out-of-range digits blank.
module bcd_to_seg7
  import temp_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (digit_i <= 4'd9)) seg_o = SEG_DIGIT[digit_i];
  end

endmodule

// File: rtl/temp_seg7_display.sv
// Converts a Celsius reading to C or F, splits it into BCD digits with a
// multicycle datapath, and multiplexes four digits onto one segment bus.
module temp_seg7_display
  import temp_display_pkg::*;
#(
  parameter int DIGIT_PERIOD = DIGIT_PERIOD_DEF,
  parameter int F_OFFSET     = F_OFFSET_DEF
) (
  input  logic                clk_200KHz,
  input  logic                reset,
  temp_seg7_display_if.slave  bus
);

  localparam int RW = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;

  state_e      state_q, state_d;
  logic        force_q;
  logic [7:0]  temp_q;
  logic        unit_q;
  logic [3:0]  cnt_q;
  logic [11:0] dvd_q, dvd_d;
  logic [3:0]  rem_q, rem_d;
  logic [4:0]  trial;
  logic [8:0]  result;
  logic [11:0] bcd_q, bcd_adj;
  logic [8:0]  bin_q;
  logic        last_div, last_bcd, input_changed;

  logic [3:0]  hund_q, tens_q, ones_q;
  logic        hund_blank_q, tens_blank_q, disp_vld_q, disp_f_q;
  logic        conv_done_q;

  logic [RW-1:0] refresh_q;
  logic [1:0]    idx_q;
  logic          scan_on_q;
  logic [3:0]    mux_digit;
  logic          mux_blank;
  logic [6:0]    digit_seg;

  assign input_changed = {bus.temperature_input, bus.unit_select} != {temp_q, unit_q};
  assign last_div      = (state_q == S_DIV) && (cnt_q == 4'(DIV_CYCLES - 1));
  assign last_bcd      = (state_q == S_BCD) && (cnt_q == 4'(BCD_CYCLES - 1));

  always_ff @(posedge clk_200KHz) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (force_q || input_changed) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_MUL;
      S_MUL:     state_d = S_DIV;
      S_DIV:     if (last_div) state_d = S_BCD;
      S_BCD:     if (last_bcd) state_d = S_LOAD;
      S_LOAD:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // One restoring-divide step by 5; quotient bits shift in behind the dividend
  always_comb begin
    trial = {rem_q, dvd_q[11]};
    if (trial >= 5'd5) begin
      rem_d = 4'(trial - 5'd5);
      dvd_d = {dvd_q[10:0], 1'b1};
    end else begin
      rem_d = trial[3:0];
      dvd_d = {dvd_q[10:0], 1'b0};
    end
    result  = unit_q ? (dvd_d[8:0] + 9'(F_OFFSET)) : {1'b0, temp_q};
    bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
  end

  always_ff @(posedge clk_200KHz) begin
    if (reset) begin
      force_q <= 1'b1;
      temp_q  <= '0;
      unit_q  <= 1'b0;
      cnt_q   <= '0;
      dvd_q   <= '0;
      rem_q   <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
    end else begin
      case (state_q)
        S_CAPTURE: begin
          temp_q  <= bus.temperature_input;
          unit_q  <= bus.unit_select;
          force_q <= 1'b0;
        end
        S_MUL: begin
          dvd_q <= 12'({temp_q, 3'b000}) + 12'(temp_q);
          rem_q <= '0;
          cnt_q <= '0;
        end
        S_DIV: begin
          dvd_q <= dvd_d;
          rem_q <= rem_d;
          cnt_q <= last_div ? 4'd0 : cnt_q + 4'd1;
          if (last_div) begin
            bin_q <= result;
            bcd_q <= '0;
          end
        end
        S_BCD: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q          <= last_bcd ? 4'd0 : cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_200KHz) begin
    if (reset) begin
      hund_q       <= '0;
      tens_q       <= '0;
      ones_q       <= '0;
      hund_blank_q <= 1'b1;
      tens_blank_q <= 1'b1;
      disp_vld_q   <= 1'b0;
      disp_f_q     <= 1'b0;
      conv_done_q  <= 1'b0;
    end else begin
      conv_done_q <= (state_q == S_LOAD);
      if (state_q == S_LOAD) begin
        hund_q       <= bcd_q[11:8];
        tens_q       <= bcd_q[7:4];
        ones_q       <= bcd_q[3:0];
        hund_blank_q <= (bcd_q[11:8] == 4'd0);
        tens_blank_q <= (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        disp_vld_q   <= 1'b1;
        disp_f_q     <= unit_q;
      end
    end
  end

  // The first wrap only enables the scan, so an[0] gets a full period too
  always_ff @(posedge clk_200KHz) begin
    if (reset) begin
      refresh_q <= '0;
      idx_q     <= '0;
      scan_on_q <= 1'b0;
    end else if (refresh_q == RW'(DIGIT_PERIOD - 1)) begin
      refresh_q <= '0;
      if (scan_on_q) idx_q <= idx_q + 2'd1;
      else           scan_on_q <= 1'b1;
    end else begin
      refresh_q <= refresh_q + RW'(1);
    end
  end

  always_comb begin
    mux_digit = ones_q;
    mux_blank = 1'b1;
    case (idx_q)
      2'd1: begin mux_digit = ones_q; mux_blank = !disp_vld_q;                end
      2'd2: begin mux_digit = tens_q; mux_blank = !disp_vld_q || tens_blank_q; end
      2'd3: begin mux_digit = hund_q; mux_blank = !disp_vld_q || hund_blank_q; end
      default: ;
    endcase
  end

  bcd_to_seg7 u_seg (
    .digit_i (mux_digit),
    .blank_i (mux_blank),
    .seg_o   (digit_seg)
  );

  assign bus.an        = scan_on_q ? ~(4'b0001 << idx_q) : 4'b1111;
  assign bus.seg       = !scan_on_q      ? SEG_BLANK :
                         (idx_q != 2'd0) ? digit_seg :
                         !disp_vld_q     ? SEG_BLANK :
                         disp_f_q        ? SEG_F     : SEG_C;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.conv_done = conv_done_q;

endmodule

// File: tb/tb_temp_seg7_display.sv
// Scoreboard bench: expected digit frames are queued when inputs change and
// checked when conv_done fires, then against a full scanned frame.
module tb_temp_seg7_display;
  logic clk_200KHz = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  logic [27:0] sb [$];
  logic [6:0] tseg [10];

  temp_seg7_display_if bus();

  temp_seg7_display #(.DIGIT_PERIOD(500), .F_OFFSET(32)) dut (
    .clk_200KHz (clk_200KHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_200KHz = ~clk_200KHz;

  task automatic tick();
    @(posedge clk_200KHz);
    #1;
  endtask

  // {an3, an2, an1, an0} segment patterns for a reading
  function automatic logic [27:0] model(int t, bit u);
    int v = u ? (t * 9) / 5 + 32 : t;
    int h = v / 100;
    int te = (v / 10) % 10;
    int o = v % 10;
    logic [6:0] sh = (h == 0) ? 7'h7F : tseg[h];
    logic [6:0] st = (h == 0 && te == 0) ? 7'h7F : tseg[te];
    logic [6:0] su = u ? 7'h0E : 7'h46;
    return {sh, st, tseg[o], su};
  endfunction

  function automatic logic [6:0] exp_active(logic [3:0] an, logic [27:0] e);
    case (an)
      4'b1110: return e[6:0];
      4'b1101: return e[13:7];
      4'b1011: return e[20:14];
      4'b0111: return e[27:21];
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] pop_exp();
    if (sb.size() == 0) return 'x;
    return sb.pop_front();
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.conv_done && n < 200);
  endtask

  task automatic capture_frame(output logic [27:0] obs);
    logic [3:0] pat;
    int t;
    obs = 'x;
    for (int k = 0; k < 4; k++) begin
      pat = ~(4'b0001 << k);
      t = 0;
      while (bus.an !== pat && t < 2600) begin
        tick();
        t++;
      end
      if (bus.an === pat) obs[k*7 +: 7] = bus.seg;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [27:0] e, f;
    reset = 1'b1;
    bus.temperature_input = 8'd25;
    bus.unit_select = 1'b0;
    repeat (3) tick();
    n_cmp++; if (bus.an !== 4'hF) begin n_err++; $display("FAIL reset_an got %b want 1111", bus.an); end
    n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.conv_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.conv_done); end
    sb.push_back(model(25, 0));
    reset = 1'b0;
    wait_done(n);
    n_cmp++; if (n !== 25) begin n_err++; $display("FAIL reset_latency got %0d want 25", n); end
    e = pop_exp();
    n_cmp++; if (bus.seg !== exp_active(bus.an, e)) begin n_err++; $display("FAIL reset_active got %h want %h", bus.seg, exp_active(bus.an, e)); end
    capture_frame(f);
    n_cmp++; if (f !== e) begin n_err++; $display("FAIL reset_frame got %h want %h", f, e); end
  endtask

  task automatic test_values(input int nv, input int tv [4], input bit uv [4]);
    int n;
    logic [27:0] e, f;
    for (int i = 0; i < nv; i++) begin
      bus.temperature_input = 8'(tv[i]);
      bus.unit_select = uv[i];
      sb.push_back(model(tv[i], uv[i]));
      wait_done(n);
      n_cmp++; if (n !== 25) begin n_err++; $display("FAIL val%0d_latency got %0d want 25", tv[i], n); end
      e = pop_exp();
      n_cmp++; if (bus.seg !== exp_active(bus.an, e)) begin n_err++; $display("FAIL val%0d_active got %h want %h", tv[i], bus.seg, exp_active(bus.an, e)); end
      capture_frame(f);
      n_cmp++; if (f !== e) begin n_err++; $display("FAIL val%0d_frame got %h want %h", tv[i], f, e); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [27:0] e, f;
    bus.temperature_input = 8'd20;
    bus.unit_select = 1'b0;
    sb.push_back(model(20, 0));
    n = 0;
    repeat (12) begin tick(); n++; end
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy_div got %b want 1", bus.busy); end
    bus.temperature_input = 8'd30;
    sb.push_back(model(30, 0));
    do begin tick(); n++; end while (!bus.conv_done && n < 200);
    n_cmp++; if (n !== 25) begin n_err++; $display("FAIL b2b_first_latency got %0d want 25", n); end
    e = pop_exp();
    n_cmp++; if (bus.seg !== exp_active(bus.an, e)) begin n_err++; $display("FAIL b2b_first_active got %h want %h", bus.seg, exp_active(bus.an, e)); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle got %b want 0", bus.busy); end
    tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL b2b_restart got %b want 1", bus.busy); end
    wait_done(n);
    n_cmp++; if (n !== 24) begin n_err++; $display("FAIL b2b_second_latency got %0d want 24", n); end
    e = pop_exp();
    n_cmp++; if (bus.seg !== exp_active(bus.an, e)) begin n_err++; $display("FAIL b2b_second_active got %h want %h", bus.seg, exp_active(bus.an, e)); end
    capture_frame(f);
    n_cmp++; if (f !== e) begin n_err++; $display("FAIL b2b_frame got %h want %h", f, e); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [27:0] e, f;
    bus.temperature_input = 8'd77;
    bus.unit_select = 1'b0;
    sb.push_back(model(77, 0));
    repeat (17) tick();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", bus.busy); end
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.an !== 4'hF) begin n_err++; $display("FAIL mid_an got %b want 1111", bus.an); end
    n_cmp++; if (bus.seg !== 7'h7F) begin n_err++; $display("FAIL mid_seg got %h want 7f", bus.seg); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_rst got %b want 0", bus.busy); end
    reset = 1'b0;
    wait_done(n);
    n_cmp++; if (n !== 25) begin n_err++; $display("FAIL mid_latency got %0d want 25", n); end
    e = pop_exp();
    n_cmp++; if (bus.seg !== exp_active(bus.an, e)) begin n_err++; $display("FAIL mid_active got %h want %h", bus.seg, exp_active(bus.an, e)); end
    capture_frame(f);
    n_cmp++; if (f !== e) begin n_err++; $display("FAIL mid_frame got %h want %h", f, e); end
  endtask

  task automatic test_scan();
    logic [3:0] cur, nxt;
    int len, t;
    bit bad;
    bad = 1'b0;
    t = 0;
    cur = bus.an;
    while (bus.an === cur && t < 2600) begin tick(); t++; end
    for (int k = 0; k < 8; k++) begin
      cur = bus.an;
      len = 0;
      while (bus.an === cur && len < 600) begin
        if ($countones(~bus.an) != 1) bad = 1'b1;
        tick();
        len++;
      end
      nxt = {cur[2:0], cur[3]};
      n_cmp++; if (len !== 500) begin n_err++; $display("FAIL scan_hold%0d got %0d want 500", k, len); end
      n_cmp++; if (bus.an !== nxt) begin n_err++; $display("FAIL scan_step%0d got %b want %b", k, bus.an, nxt); end
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL scan_onehot got %b want 0", bad); end
  endtask

  initial begin
    int tv [4];
    bit uv [4];
    tseg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    bus.temperature_input = 8'd0;
    bus.unit_select = 1'b0;
    test_reset();
    tv = '{25, 0, 255, 0};
    uv = '{1'b1, 1'b1, 1'b1, 1'b0};
    test_values(4, tv, uv);
    test_back_to_back();
    test_reset_mid();
    tv = '{100, 100, 0, 0};
    uv = '{1'b1, 1'b0, 1'b0, 1'b0};
    test_values(2, tv, uv);
    test_scan();
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL sb_empty got %0d want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/temp_seg7_display.md
TEMP_SEG7_DISPLAY -- requirements
Module: temp_seg7_display

Interface
REQ-001 Parameter DIGIT_PERIOD, default 500; clk_200KHz cycles each digit is driven (100 Hz frame).
REQ-002 Parameter F_OFFSET, default 32; Fahrenheit additive offset.
REQ-003 clk_200KHz  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 temperature_input  input  8  unsigned integer degrees C (0..255) from the sensor interface's temperature_output.
REQ-006 unit_select  input  1  0 = Celsius, 1 = Fahrenheit.
REQ-007 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-008 an  output  4  active-low digit anodes; an[0] rightmost.
REQ-009 busy  output  1  high while a conversion is in progress.
REQ-010 conv_done  output  1  one-cycle pulse when new digits are loaded.

Function
REQ-011 FSM states: IDLE, CAPTURE, MUL, DIV, BCD, LOAD; 1 cycle each except DIV (12 cycles) and BCD (9 cycles).
REQ-012 IDLE -> CAPTURE when {temperature_input, unit_select} differs from the last captured pair, or the post-reset force flag is set.
REQ-013 CAPTURE latches temperature_input and unit_select and clears the force flag; these latched values are used for the whole conversion.
REQ-014 MUL: product = C*9 in 12 bits (max 2295, no overflow).
REQ-015 DIV: 12-iteration restoring divide of the product by 5; quotient is 9 bits, remainder is discarded (floor).
REQ-016 Result: F mode = quotient + F_OFFSET (max 491); C mode = C zero-extended to 9 bits; 9-bit result, never saturates.
REQ-017 BCD: 9-cycle shift-add-3 conversion to hundreds, tens and ones.
REQ-018 LOAD: display registers update, conv_done = 1, then return to IDLE.
REQ-019 Latency: CAPTURE to LOAD is exactly 24 cycles in both units; digits change on the cycle after LOAD.
REQ-020 busy = 1 in every state except IDLE.
REQ-021 Input changes while busy are ignored; they are detected on return to IDLE and trigger a fresh conversion.
REQ-022 Display mapping: an[3] hundreds, an[2] tens, an[1] ones, an[0] unit glyph (C = 7'h46, F = 7'h0E).
REQ-023 Leading-zero blanking: hundreds blank (7'h7F) if 0; tens blank if hundreds is blank and tens is 0; ones always shown.
REQ-024 Scan: a refresh counter wraps at DIGIT_PERIOD-1; the active digit steps an[0] -> an[1] -> an[2] -> an[3] -> an[0].
REQ-025 Exactly one an bit is low at any time after the first scan step; the scan runs independently of the conversion FSM.

Reset
REQ-026 reset: FSM -> IDLE, force flag set, refresh counter and digit index = 0.
REQ-027 reset outputs: an = 4'b1111, seg = 7'h7F, busy = 0, conv_done = 0.
REQ-028 Display registers reset to blank, so a blank frame is shown until the first LOAD.
REQ-029 reset asserted mid-conversion aborts it; after release the current input is converted (force flag).
REQ-030 The first CAPTURE occurs on the first cycle after reset is released.

Structure
REQ-031 Package temp_display_pkg holds: state enum, glyph constants (BLANK, C, F), digit-to-segment table, default DIGIT_PERIOD and F_OFFSET.
REQ-032 Sub-module bcd_to_seg7: combinational, 4-bit digit plus blank flag -> 7-bit active-low segments; instantiated once on the scan mux output.

Verification
REQ-033 Reset, C mode, input 25 -> conv_done 25 cycles after release; digits blank,2,5,C (7'h7F, 7'h24, 7'h12, 7'h46).
REQ-034 F mode, input 25 -> 77F; input 0 -> 32F; input 255 -> 491F; C mode input 0 -> blank,blank,0,C.
REQ-035 Input 20 -> 30 on the 10th cycle of DIV -> first conversion shows 20; a second conversion starts 1 cycle after LOAD and shows 30.
REQ-036 reset pulsed during BCD -> an = 1111 and seg = 7F the next cycle; after release, a full conversion of the held input completes in 25 cycles.
REQ-037 Scan check: an sequence 1110, 1101, 1011, 0111, each held exactly 500 cycles, repeating; never two anodes low.
REQ-038 unit_select toggled with input constant at 100 -> re-conversion: 212F, then 100C.
